// File: rtl/ddr3_stream_tester.sv
// DDR3 stream traffic generator/checker: writes WORDS pattern words per pass
// to the controller write stream, reads them back and compares each word
// against an independently regenerated pattern.
module ddr3_stream_tester #(
  parameter int          DATA_W = 16,
  parameter int          WORDS  = 1024,
  parameter int          PASSES = 1,
  parameter int          ERR_W  = 16,
  parameter int unsigned SEED   = 16'hA5A5,
  parameter int unsigned POLY   = 16'hB400,
  localparam int         CW     = $clog2(WORDS + 1),
  localparam int         FW     = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_calib_complete,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              tx_tvalid,
  output logic [DATA_W-1:0] tx_tdata,
  input  logic              tx_tready,
  input  logic              rx_tvalid,
  input  logic [DATA_W-1:0] rx_tdata,
  output logic              rx_tready,
  output logic              busy,
  output logic              test_pass,
  output logic              test_fail,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [FW-1:0]     first_err_idx,
  output logic [15:0]       pass_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_CHECK, S_DONE} state_t;

  localparam logic [DATA_W-1:0] SEED_T  = DATA_W'(SEED);
  localparam logic [DATA_W-1:0] SEED_V  = (SEED_T == '0) ? DATA_W'(1) : SEED_T;
  localparam logic [DATA_W-1:0] POLY_V  = DATA_W'(POLY);
  localparam logic [DATA_W-1:0] CB5     = DATA_W'({((DATA_W + 1) / 2){2'b01}});
  localparam logic [CW-1:0]     WORDS_C = CW'(WORDS);
  localparam logic [CW-1:0]     LAST    = CW'(WORDS - 1);

  state_t              state, next_state;
  logic [1:0]          mode_q;
  logic [CW-1:0]       sent, recv;
  logic [DATA_W-1:0]   gen_lfsr, chk_lfsr;
  logic                cal_lost;
  logic                tx_fire, rx_fire, last_pass;
  logic                enter_run, write_entry, read_entry;
  logic [DATA_W-1:0]   exp_word;

  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] x);
    return (x >> 1) ^ (x[0] ? POLY_V : '0);
  endfunction

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                input logic [CW-1:0] idx,
                                                input logic [DATA_W-1:0] lfsr,
                                                input logic inv);
    logic [DATA_W-1:0] w;
    int unsigned       sh;
    sh = 32'(idx) % 32'(DATA_W);
    unique case (m)
      2'd0:    w = DATA_W'(idx);
      2'd1:    w = lfsr;
      2'd2:    w = DATA_W'(1) << sh;
      default: w = idx[0] ? ~CB5 : CB5;
    endcase
    return w ^ {DATA_W{inv}};
  endfunction

  assign tx_fire   = tx_tvalid && tx_tready;
  assign rx_fire   = rx_tvalid && rx_tready;
  assign last_pass = (PASSES != 0) && ({16'd0, pass_cnt} + 32'd1 == 32'(PASSES));
  assign exp_word  = pattern(mode_q, recv, chk_lfsr, pass_cnt[0]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state and output decode; calibration loss overrides every busy state
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    tx_tvalid  = 1'b0;
    tx_tdata   = '0;
    rx_tready  = 1'b0;
    test_pass  = 1'b0;
    unique case (state)
      S_IDLE: if (start && init_calib_complete) next_state = S_WRITE;
      S_WRITE: begin
        busy      = 1'b1;
        tx_tvalid = (sent < WORDS_C);
        tx_tdata  = tx_tvalid ? pattern(mode_q, sent, gen_lfsr, pass_cnt[0]) : '0;
        if (!init_calib_complete)         next_state = S_DONE;
        else if (tx_fire && sent == LAST) next_state = S_READ;
      end
      S_READ: begin
        busy      = 1'b1;
        rx_tready = (recv < WORDS_C);
        if (!init_calib_complete)         next_state = S_DONE;
        else if (rx_fire && recv == LAST) next_state = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (!init_calib_complete || last_pass) next_state = S_DONE;
        else                                   next_state = S_WRITE;
      end
      S_DONE: begin
        test_pass = (err_cnt == '0) && !cal_lost;
        if (start && init_calib_complete) next_state = S_WRITE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign enter_run   = (state == S_IDLE || state == S_DONE) && next_state == S_WRITE;
  assign write_entry = (state != S_WRITE) && next_state == S_WRITE;
  assign read_entry  = (state == S_WRITE) && next_state == S_READ;

  // Generator, checker, counters and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q        <= '0;
      sent          <= '0;
      recv          <= '0;
      gen_lfsr      <= SEED_V;
      chk_lfsr      <= SEED_V;
      cal_lost      <= 1'b0;
      test_fail     <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      pass_cnt      <= '0;
    end else begin
      if (enter_run) begin
        mode_q        <= mode;
        err_cnt       <= '0;
        test_fail     <= 1'b0;
        first_err_idx <= '0;
        pass_cnt      <= '0;
        cal_lost      <= 1'b0;
      end
      if (write_entry) begin
        sent     <= '0;
        recv     <= '0;
        gen_lfsr <= SEED_V;
      end else begin
        if (tx_fire) begin
          sent     <= sent + CW'(1);
          gen_lfsr <= lfsr_next(gen_lfsr);
        end
        if (read_entry) chk_lfsr <= SEED_V;
        if (rx_fire) begin
          recv     <= recv + CW'(1);
          chk_lfsr <= lfsr_next(chk_lfsr);
          if (rx_tdata != exp_word) begin
            if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
            if (err_cnt == '0) first_err_idx <= FW'(recv);
            test_fail <= 1'b1;
          end
        end
      end
      if (state == S_CHECK && init_calib_complete) pass_cnt <= pass_cnt + 16'd1;
      if (busy && !init_calib_complete) begin
        cal_lost  <= 1'b1;
        test_fail <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ddr3_stream_tester.md
Name: ddr3_stream_tester

Overview:
Parametrised DDR3 traffic generator and checker that drives the write stream of the DDR3 AXI-Stream read/write controller and checks its read stream.
- Once calibration completes, writes WORDS pattern words per pass, then reads back the same number and compares each word against an independently regenerated pattern.
- Supports four pattern modes and multi-pass or continuous operation.
- Reports pass/fail, a saturating error count, the first failing index and the number of completed passes; sits at the board top level between the DDR3 controller and the status LEDs.

Parameters:
DATA_W, 16, stream data width in bits (>=8).
WORDS, 1024, words written and read per pass (>=1).
PASSES, 1, passes per run; 0 = run continuously until a new start or reset.
ERR_W, 16, width of err_cnt (saturating).
SEED, 16'hA5A5, LFSR seed, zero-extended or truncated to DATA_W; a zero value is replaced by 1.
POLY, 16'hB400, Galois LFSR feedback mask, zero-extended or truncated to DATA_W.

Ports:
clk  input  1  system clock; all logic is on this single clock.
rst_n  input  1  asynchronous active-low reset.
init_calib_complete  input  1  DDR3 calibration done, from the controller.
start  input  1  starts a run when sampled high in IDLE or DONE.
mode  input  2  pattern: 0 = increment, 1 = LFSR, 2 = walking one, 3 = checkerboard; latched on start.
tx_tvalid  output  1  write-stream valid, to the controller's s_axis.
tx_tdata  output  DATA_W  write-stream data.
tx_tready  input  1  write-stream ready.
rx_tvalid  input  1  read-stream valid, from the controller's m_axis.
rx_tdata  input  DATA_W  read-stream data.
rx_tready  output  1  read-stream ready.
busy  output  1  high in WRITE, READ and CHECK.
test_pass  output  1  high in DONE when err_cnt==0 and the calibration-loss flag is clear.
test_fail  output  1  sticky per run; set on any mismatch or on calibration loss.
err_cnt  output  ERR_W  mismatch count; saturates at all-ones.
first_err_idx  output  $clog2(WORDS)  word index of the first mismatch in the run (max(1, ...) width).
pass_cnt  output  16  completed passes; wraps modulo 2^16.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; every output 0, including tx_tdata; counters, latched mode and LFSR (reloaded to SEED) cleared.
- States: IDLE, WRITE, READ, CHECK, DONE.
- IDLE -> WRITE when start && init_calib_complete; otherwise stay in IDLE, with start ignored.
- Entering WRITE from IDLE or DONE:
  - latch mode;
  - clear err_cnt, test_fail, first_err_idx, pass_cnt, the calibration-loss flag and the generator index;
  - load the generator LFSR with SEED.
- WRITE:
  - tx_tvalid is high from the first WRITE cycle (one cycle after start is sampled) while sent < WORDS.
  - A beat transfers on tx_tvalid && tx_tready; the generator then advances.
  - tx_tdata and tx_tvalid stay stable while tx_tvalid && !tx_tready.
  - After beat WORDS-1 transfers, tx_tvalid drops in the same edge and the state moves to READ.
- READ:
  - rx_tready is high while recv < WORDS; it is low in every other state, so rx beats are never consumed outside READ.
  - The checker generator restarts at index 0 with the same seed on READ entry.
  - Each rx_tvalid && rx_tready beat is compared with the expected word. On mismatch:
    - err_cnt increments, saturating;
    - test_fail sets;
    - first_err_idx captures recv, only if this is the first error of the run.
  - After beat WORDS-1, move to CHECK.
- CHECK (one cycle): pass_cnt increments; if PASSES != 0 && pass_cnt+1 == PASSES go to DONE, else go to WRITE, keeping err_cnt, test_fail and first_err_idx.
- DONE: outputs hold. start && init_calib_complete re-arms (go to WRITE with the run clears above).
- Pattern for index i and pass p, with inv = {DATA_W{p[0]}} (odd passes are inverted):
  - mode 0: (i mod 2^DATA_W) ^ inv.
  - mode 1: LFSR value ^ inv, where next = (x >> 1) ^ (x[0] ? POLY : 0).
  - mode 2: (1 << (i mod DATA_W)) ^ inv.
  - mode 3: (i even ? {5 repeated} : {A repeated}) ^ inv.
- Calibration loss: if init_calib_complete falls in WRITE, READ or CHECK, go to DONE next cycle, set test_fail and the calibration-loss flag; test_pass stays 0.
- Counters sent and recv are $clog2(WORDS+1) bits wide and clear on each WRITE entry.
- Simultaneous events: start in WRITE, READ or CHECK is ignored. A tx beat and calibration loss in the same cycle: the beat counts, then the block aborts.

Test Plan:
1. init_calib_complete=0, pulse start -> remains IDLE; busy=0, tx_tvalid=0, test_pass=0 for 100 cycles.
2. WORDS=8, PASSES=1, mode 0, loopback FIFO model, always ready -> tx_tdata 0..7, rx checked, DONE, test_pass=1, err_cnt=0, pass_cnt=1.
3. Same as 2 with tx_tready random 50% -> tx_tdata stable across stalls, exactly 8 beats, test_pass=1.
4. mode 1, SEED=A5A5, model flips bit 0 of rx word 3 -> err_cnt=1, first_err_idx=3, test_fail=1, test_pass=0.
5. PASSES=2, mode 3 -> pass 0 writes 5555,AAAA,...; pass 1 writes AAAA,5555,...; pass_cnt=2, test_pass=1.
6. Drop init_calib_complete mid-READ -> DONE next cycle, test_fail=1. Separately, assert rst_n low mid-WRITE -> all outputs 0 immediately without waiting for a clock edge.
